// File: rtl/frame_unloader.sv
// Unloads a parallel frame captured from an upstream buffer as a stream of words
// with valid/ready handshaking, then presents a wrapping checksum of the frame.
module frame_unloader #(
    parameter int n = 32,
    parameter int m = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [0:m-1][n-1:0]   data_i,
    input  logic                  full_i,
    output logic [n-1:0]          dat_o,
    output logic                  vld_o,
    input  logic                  rdy_i,
    output logic                  last_o,
    output logic [n-1:0]          sum_o,
    output logic                  sum_vld_o,
    output logic                  busy_o,
    output logic [7:0]            frame_cnt_o,
    output logic                  ovf_o
);

    localparam int IW = $clog2(m);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        SUM
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                full_q;
    logic                capture;
    logic                xfer;
    logic [IW-1:0]       idx_q;
    logic [n-1:0]        acc_q;
    logic [n-1:0]        sum_q;
    logic [7:0]          cnt_q;
    logic                ovf_q;
    logic [0:m-1][n-1:0] frame_q;

    assign capture = full_i & ~full_q;
    assign xfer    = vld_o & rdy_i;

    always_comb begin
        state_d   = state_q;
        vld_o     = 1'b0;
        last_o    = 1'b0;
        dat_o     = '0;
        sum_vld_o = 1'b0;
        busy_o    = 1'b1;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (capture) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                vld_o  = 1'b1;
                dat_o  = frame_q[idx_q];
                last_o = (idx_q == IW'(m - 1));
                if (rdy_i && last_o) begin
                    state_d = SUM;
                end
            end
            SUM: begin
                sum_vld_o = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The checksum and frame count are committed on the final transfer so they
    // are already visible during the single SUM cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            full_q  <= 1'b1;
            idx_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            full_q  <= full_i;
            if (capture) begin
                if (state_q == IDLE) begin
                    idx_q <= '0;
                    acc_q <= '0;
                end else begin
                    ovf_q <= 1'b1;
                end
            end
            if (xfer) begin
                idx_q <= idx_q + 1'b1;
                acc_q <= acc_q + dat_o;
                if (last_o) begin
                    sum_q <= acc_q + dat_o;
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    // Frame storage needs no reset; it is always reloaded before being read.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && capture) begin
            frame_q <= data_i;
        end
    end

    assign sum_o       = sum_q;
    assign frame_cnt_o = cnt_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_frame_unloader.sv
// Directed bench for frame_unloader (n=32, m=4): a vector table for streaming,
// backpressure and wrap, then hand sequences for overflow, back-to-back and reset.
module tb_frame_unloader;

    localparam int N = 32;
    localparam int M = 4;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic [0:M-1][N-1:0] data_i = '0;
    logic                full_i = 1'b0;
    logic                rdy_i = 1'b1;
    logic [N-1:0]        dat_o;
    logic                vld_o;
    logic                last_o;
    logic [N-1:0]        sum_o;
    logic                sum_vld_o;
    logic                busy_o;
    logic [7:0]          frame_cnt_o;
    logic                ovf_o;

    int vectors = 0;
    int miscompares = 0;

    frame_unloader #(.n(N), .m(M)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .full_i      (full_i),
        .dat_o       (dat_o),
        .vld_o       (vld_o),
        .rdy_i       (rdy_i),
        .last_o      (last_o),
        .sum_o       (sum_o),
        .sum_vld_o   (sum_vld_o),
        .busy_o      (busy_o),
        .frame_cnt_o (frame_cnt_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic                rst;
        logic                full;
        logic                rdy;
        logic [0:M-1][N-1:0] data;
        logic                vld;
        logic [N-1:0]        dat;
        logic                last;
        logic                sv;
        logic [N-1:0]        sum;
        logic                busy;
        logic [7:0]          cnt;
        logic                ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic full, logic rdy, logic [0:M-1][N-1:0] data,
                                logic vld, logic [N-1:0] dat, logic last, logic sv,
                                logic [N-1:0] sum, logic busy, logic [7:0] cnt, logic ovf);
        vec_t v;
        v.rst = rst; v.full = full; v.rdy = rdy; v.data = data;
        v.vld = vld; v.dat = dat; v.last = last; v.sv = sv;
        v.sum = sum; v.busy = busy; v.cnt = cnt; v.ovf = ovf;
        return v;
    endfunction

    task automatic apply_stimulus(input logic rst, input logic full, input logic rdy);
        rst_i  = rst;
        full_i = full;
        rdy_i  = rdy;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_output(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic vld, input logic [N-1:0] dat,
                             input logic last, input logic sv, input logic [N-1:0] sum,
                             input logic busy, input logic [7:0] cnt, input logic ovf);
        check_output({tag, ".vld"},  N'(vld_o),       N'(vld));
        check_output({tag, ".dat"},  dat_o,           dat);
        check_output({tag, ".last"}, N'(last_o),      N'(last));
        check_output({tag, ".sv"},   N'(sum_vld_o),   N'(sv));
        check_output({tag, ".sum"},  sum_o,           sum);
        check_output({tag, ".busy"}, N'(busy_o),      N'(busy));
        check_output({tag, ".cnt"},  N'(frame_cnt_o), N'(cnt));
        check_output({tag, ".ovf"},  N'(ovf_o),       N'(ovf));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [0:M-1][N-1:0] d1;
        logic [0:M-1][N-1:0] dw;
        logic [0:M-1][N-1:0] d9;
        logic [0:M-1][N-1:0] d5;
        d1 = {32'd1, 32'd2, 32'd3, 32'd4};
        dw = {32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
        d9 = {32'd9, 32'd9, 32'd9, 32'd9};
        d5 = {32'd5, 32'd6, 32'd7, 32'd8};

        // Streaming frame: reset, capture, four transfers, SUM
        vecs.push_back(mk(1, 0, 1, d1, 0, 0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1, d1, 0, 0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 1, 1, d1, 1, 1, 0, 0, 0,  1, 0, 0));
        vecs.push_back(mk(0, 1, 1, d1, 1, 2, 0, 0, 0,  1, 0, 0));
        vecs.push_back(mk(0, 1, 1, d1, 1, 3, 0, 0, 0,  1, 0, 0));
        vecs.push_back(mk(0, 1, 1, d1, 1, 4, 1, 0, 0,  1, 0, 0));
        vecs.push_back(mk(0, 1, 1, d1, 0, 0, 0, 1, 10, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, d1, 0, 0, 0, 0, 10, 0, 1, 0));
        // Backpressure on word 2 for three cycles
        vecs.push_back(mk(0, 0, 1, d1, 0, 0, 0, 0, 10, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, d1, 1, 1, 0, 0, 10, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, d1, 1, 2, 0, 0, 10, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, d1, 1, 2, 0, 0, 10, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, d1, 1, 2, 0, 0, 10, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, d1, 1, 2, 0, 0, 10, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, d1, 1, 3, 0, 0, 10, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, d1, 1, 4, 1, 0, 10, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, d1, 0, 0, 0, 1, 10, 1, 2, 0));
        // Wrapping checksum; data_i changes after capture must not leak in
        vecs.push_back(mk(0, 0, 1, dw, 0, 0,            0, 0, 10, 0, 2, 0));
        vecs.push_back(mk(0, 1, 1, dw, 1, 32'hFFFFFFFF, 0, 0, 10, 1, 2, 0));
        vecs.push_back(mk(0, 1, 1, d9, 1, 1,            0, 0, 10, 1, 2, 0));
        vecs.push_back(mk(0, 1, 1, d9, 1, 0,            0, 0, 10, 1, 2, 0));
        vecs.push_back(mk(0, 1, 1, d9, 1, 0,            1, 0, 10, 1, 2, 0));
        vecs.push_back(mk(0, 1, 1, d9, 0, 0,            0, 1, 0,  1, 3, 0));
        vecs.push_back(mk(0, 0, 1, d1, 0, 0,            0, 0, 0,  0, 3, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            data_i = vecs[i].data;
            apply_stimulus(vecs[i].rst, vecs[i].full, vecs[i].rdy);
            check_all($sformatf("row%0d", i), vecs[i].vld, vecs[i].dat, vecs[i].last, vecs[i].sv,
                      vecs[i].sum, vecs[i].busy, vecs[i].cnt, vecs[i].ovf);
        end

        // Overflow: second rising edge of full_i during SEND
        apply_stimulus(0, 1, 1); check_all("ovf0", 1, 1, 0, 0, 0,  1, 3, 0);
        apply_stimulus(0, 0, 1); check_all("ovf1", 1, 2, 0, 0, 0,  1, 3, 0);
        apply_stimulus(0, 1, 1); check_all("ovf2", 1, 3, 0, 0, 0,  1, 3, 1);
        apply_stimulus(0, 0, 1); check_all("ovf3", 1, 4, 1, 0, 0,  1, 3, 1);
        apply_stimulus(0, 0, 1); check_all("ovf4", 0, 0, 0, 1, 10, 1, 4, 1);
        apply_stimulus(0, 0, 1); check_all("ovf5", 0, 0, 0, 0, 10, 0, 4, 1);
        apply_stimulus(0, 0, 1); check_all("ovf6", 0, 0, 0, 0, 10, 0, 4, 1);

        // Back-to-back: new capture edge in the first IDLE cycle after SUM
        apply_stimulus(0, 1, 1); check_all("b2b0", 1, 1, 0, 0, 10, 1, 4, 1);
        apply_stimulus(0, 0, 1); check_all("b2b1", 1, 2, 0, 0, 10, 1, 4, 1);
        apply_stimulus(0, 0, 1); check_all("b2b2", 1, 3, 0, 0, 10, 1, 4, 1);
        apply_stimulus(0, 0, 1); check_all("b2b3", 1, 4, 1, 0, 10, 1, 4, 1);
        apply_stimulus(0, 0, 1); check_all("b2b4", 0, 0, 0, 1, 10, 1, 5, 1);
        data_i = d5;
        apply_stimulus(0, 0, 1); check_all("b2b5", 0, 0, 0, 0, 10, 0, 5, 1);
        apply_stimulus(0, 1, 1); check_all("b2b6", 1, 5, 0, 0, 10, 1, 5, 1);
        apply_stimulus(0, 1, 1); check_all("b2b7", 1, 6, 0, 0, 10, 1, 5, 1);
        apply_stimulus(0, 1, 1); check_all("b2b8", 1, 7, 0, 0, 10, 1, 5, 1);
        apply_stimulus(0, 1, 1); check_all("b2b9", 1, 8, 1, 0, 10, 1, 5, 1);
        apply_stimulus(0, 1, 1); check_all("b2bA", 0, 0, 0, 1, 26, 1, 6, 1);

        // Reset mid-SEND aborts the frame; full_i held high across release
        apply_stimulus(0, 0, 1); check_all("rst0", 0, 0, 0, 0, 26, 0, 6, 1);
        apply_stimulus(0, 1, 1); check_all("rst1", 1, 5, 0, 0, 26, 1, 6, 1);
        apply_stimulus(0, 1, 1); check_all("rst2", 1, 6, 0, 0, 26, 1, 6, 1);
        apply_stimulus(1, 1, 1); check_all("rst3", 0, 0, 0, 0, 0,  0, 0, 0);
        apply_stimulus(0, 1, 1); check_all("rst4", 0, 0, 0, 0, 0,  0, 0, 0);
        apply_stimulus(0, 1, 1); check_all("rst5", 0, 0, 0, 0, 0,  0, 0, 0);
        apply_stimulus(0, 0, 1); check_all("rst6", 0, 0, 0, 0, 0,  0, 0, 0);
        apply_stimulus(0, 1, 1); check_all("rst7", 1, 5, 0, 0, 0,  1, 0, 0);
        apply_stimulus(0, 1, 1); check_all("rst8", 1, 6, 0, 0, 0,  1, 0, 0);
        apply_stimulus(0, 1, 1); check_all("rst9", 1, 7, 0, 0, 0,  1, 0, 0);
        apply_stimulus(0, 1, 1); check_all("rstA", 1, 8, 1, 0, 0,  1, 0, 0);
        apply_stimulus(0, 1, 1); check_all("rstB", 0, 0, 0, 1, 26, 1, 1, 0);

        // Frame counter wraps after 256 frames
        apply_stimulus(1, 0, 1);
        for (int f = 1; f <= 256; f++) begin
            apply_stimulus(0, 0, 1);
            apply_stimulus(0, 1, 1);
            for (int k = 0; k < M; k++) begin
                apply_stimulus(0, 1, 1);
            end
            check_output($sformatf("wrap%0d.sv", f),  N'(sum_vld_o),   N'(1'b1));
            check_output($sformatf("wrap%0d.cnt", f), N'(frame_cnt_o), N'(f % 256));
        end
        check_output("wrap.sum", sum_o, 32'd26);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
